// File: rtl/recv_sched.sv
// recv_sched: round-robin arbiter that time-shares one frame receiver among
// NUM_PORTS byte-stream sources, tags receiver results with the source
// index, and aborts a frame that overruns MAX_FRAME_CYCLES.
module recv_sched #(
  parameter int unsigned NUM_PORTS        = 4,
  parameter logic [15:0] MAX_FRAME_CYCLES = 16'd1600
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   port_req,
  input  logic [8*NUM_PORTS-1:0] port_data,
  output logic [NUM_PORTS-1:0]   port_gnt,
  output logic [7:0]             rx_data,
  output logic                   rx_start,
  output logic                   rx_rst,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_out,
  input  logic                   rx_vld,
  output logic [7:0]             out_data,
  output logic                   out_vld,
  output logic [2:0]             out_port,
  output logic                   done,
  output logic [2:0]             done_port,
  output logic                   done_timeout,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            timeout_cnt
);

  localparam int unsigned PW   = 3;
  localparam int unsigned PW1  = PW + 1;
  localparam int unsigned MAXP = 8;
  localparam int unsigned DW   = 8 * MAXP;
  localparam int unsigned CW   = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_ABORT
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        win_q, win_d;
  logic [PW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic                 start_q, start_d;
  logic                 rrst_q, rrst_d;
  logic                 done_q, done_d;
  logic [PW-1:0]        done_port_q, done_port_d;
  logic                 done_to_q, done_to_d;
  logic [CW-1:0]        frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]        timeout_cnt_q, timeout_cnt_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_vld_q, out_vld_d;
  logic [PW-1:0]        out_port_q, out_port_d;

  logic [MAXP-1:0]      req_ext;
  logic [DW-1:0]        data_ext;
  logic                 pick_vld;
  logic [PW-1:0]        pick;
  logic [NUM_PORTS-1:0] pick_oh;

  // Pad request/data buses to 8 ports so a 3-bit index selects exactly
  assign req_ext  = MAXP'(port_req);
  assign data_ext = DW'(port_data);

  // Round-robin search starting just after the previous winner
  always_comb begin
    logic [PW1-1:0] cand;
    cand     = '0;
    pick_vld = 1'b0;
    pick     = last_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, last_q} + PW1'(1) + PW1'(i);
      if (cand >= PW1'(NUM_PORTS)) begin
        cand = cand - PW1'(NUM_PORTS);
      end
      if (!pick_vld && req_ext[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[PW-1:0];
      end
    end
  end

  // One-hot grant vector for the selected port
  always_comb begin
    pick_oh = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pick_oh[i] = (pick == PW'(i));
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    start_d       = 1'b0;
    rrst_d        = 1'b0;
    done_d        = 1'b0;
    done_port_d   = done_port_q;
    done_to_d     = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    timeout_cnt_d = timeout_cnt_q;

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (pick_vld && rx_ready) begin
          win_d   = pick;
          gnt_d   = pick_oh;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // Receiver still shows ready the cycle after start, so cnt==0 is ignored
        if ((cnt_q != '0) && rx_ready) begin
          gnt_d       = '0;
          done_d      = 1'b1;
          done_port_d = win_q;
          if (frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
          last_d  = win_q;
          state_d = S_IDLE;
        end else if (cnt_q == (MAX_FRAME_CYCLES - CW'(1))) begin
          gnt_d       = '0;
          rrst_d      = 1'b1;
          done_d      = 1'b1;
          done_to_d   = 1'b1;
          done_port_d = win_q;
          if (timeout_cnt_q != '1) begin
            timeout_cnt_d = timeout_cnt_q + CW'(1);
          end
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte presented by the granted port reaches the receiver one cycle later
  always_comb begin
    rx_data_d = 8'h00;
    if (|gnt_q) begin
      rx_data_d = data_ext[{win_q, 3'b000} +: 8];
    end
  end

  // Result stream retimed and tagged with the owner of the current/last frame
  always_comb begin
    out_vld_d  = rx_vld;
    out_data_d = rx_out;
    out_port_d = out_port_q;
    if (rx_vld) begin
      out_port_d = win_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      win_q         <= '0;
      last_q        <= PW'(NUM_PORTS - 1);
      cnt_q         <= '0;
      gnt_q         <= '0;
      start_q       <= 1'b0;
      rrst_q        <= 1'b0;
      done_q        <= 1'b0;
      done_port_q   <= '0;
      done_to_q     <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      rx_data_q     <= 8'h00;
      out_data_q    <= 8'h00;
      out_vld_q     <= 1'b0;
      out_port_q    <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      start_q       <= start_d;
      rrst_q        <= rrst_d;
      done_q        <= done_d;
      done_port_q   <= done_port_d;
      done_to_q     <= done_to_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      rx_data_q     <= rx_data_d;
      out_data_q    <= out_data_d;
      out_vld_q     <= out_vld_d;
      out_port_q    <= out_port_d;
    end
  end

  assign port_gnt     = gnt_q;
  assign rx_data      = rx_data_q;
  assign rx_start     = start_q;
  assign rx_rst       = rrst_q;
  assign done         = done_q;
  assign done_port    = done_port_q;
  assign done_timeout = done_to_q;
  assign frame_cnt    = frame_cnt_q;
  assign timeout_cnt  = timeout_cnt_q;
  assign out_data     = out_data_q;
  assign out_vld      = out_vld_q;
  assign out_port     = out_port_q;

endmodule

// File: tb/tb_recv_sched.sv
// Directed bench for recv_sched. Frame limit is 32 cycles so that a 30-cycle
// frame completes normally while timeout and the simultaneous corner stay short.
module tb_recv_sched;

  localparam int unsigned NP   = 4;
  localparam logic [15:0] MAXC = 16'd32;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   port_req;
  logic [8*NP-1:0] port_data;
  logic [NP-1:0]   port_gnt;
  logic [7:0]      rx_data;
  logic            rx_start;
  logic            rx_rst;
  logic            rx_ready;
  logic [7:0]      rx_out;
  logic            rx_vld;
  logic [7:0]      out_data;
  logic            out_vld;
  logic [2:0]      out_port;
  logic            done;
  logic [2:0]      done_port;
  logic            done_timeout;
  logic [15:0]     frame_cnt;
  logic [15:0]     timeout_cnt;

  int unsigned n_vec;
  int unsigned n_bad;

  recv_sched #(.NUM_PORTS(NP), .MAX_FRAME_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_data(port_data), .port_gnt(port_gnt),
    .rx_data(rx_data), .rx_start(rx_start), .rx_rst(rx_rst),
    .rx_ready(rx_ready), .rx_out(rx_out), .rx_vld(rx_vld),
    .out_data(out_data), .out_vld(out_vld), .out_port(out_port),
    .done(done), .done_port(done_port), .done_timeout(done_timeout),
    .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] pd1;
    logic       rdy;
    logic       vld;
    logic [7:0] rout;
    logic [3:0] e_gnt;
    logic       e_start;
    logic       e_rrst;
    logic       e_done;
    logic [2:0] e_dport;
    logic       e_dto;
    logic       e_ovld;
    logic [7:0] e_odata;
    logic [2:0] e_oport;
    logic [7:0] e_rxd;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, port_gnt, rx_start, rx_rst, done, done_port, done_timeout,
            out_vld, out_data, out_port, rx_data};
  endfunction

  // Grant port p from IDLE, hold for nbusy BUSY cycles, complete with rx_ready
  task automatic grant_frame(input string nm, input int unsigned p, input int unsigned nbusy);
    logic [3:0]  eg;
    int unsigned w;
    int unsigned held;
    eg = 4'b0001 << p;
    rx_ready = 1'b1;
    tick();
    w = 0;
    while (port_gnt == '0 && w < 50) begin
      tick();
      w++;
    end
    check({nm, " gnt"}, 32'(port_gnt), 32'(eg));
    check({nm, " start"}, 32'(rx_start), 32'd1);
    check({nm, " idle gap"}, w, 32'd0);
    rx_ready = 1'b0;
    held = 0;
    for (int unsigned k = 0; k < nbusy; k++) begin
      tick();
      if (port_gnt == eg && !rx_start && !rx_rst) held++;
    end
    check({nm, " hold"}, held, nbusy);
    rx_ready = 1'b1;
    tick();
    check({nm, " done"}, 32'({done, done_timeout, rx_rst, port_gnt}), 32'({1'b1, 1'b0, 1'b0, 4'b0000}));
    check({nm, " done_port"}, 32'(done_port), p);
  endtask

  initial begin
    logic [3:0] eg;
    int unsigned held;
    n_vec = 0;
    n_bad = 0;

    //                req      pd1    rdy   vld   rout   gnt      st    rr    dn    dp    dto   ov    od     op    rxd
    tbl[0] = '{4'b0010, 8'h55, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00};
    tbl[1] = '{4'b0010, 8'h55, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00};
    tbl[2] = '{4'b0010, 8'h55, 1'b1, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00};
    tbl[3] = '{4'b0010, 8'h55, 1'b1, 1'b0, 8'h00, 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h55};
    tbl[4] = '{4'b0010, 8'hD5, 1'b1, 1'b0, 8'h00, 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'hD5};
    tbl[5] = '{4'b0000, 8'h11, 1'b0, 1'b1, 8'hA3, 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'hA3, 3'd1, 8'h11};
    tbl[6] = '{4'b0000, 8'h22, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 3'd1, 8'h22};
    tbl[7] = '{4'b0000, 8'h33, 1'b1, 1'b1, 8'h5C, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 8'h5C, 3'd1, 8'h00};

    rst       = 1'b0;
    port_req  = '0;
    port_data = '0;
    rx_ready  = 1'b0;
    rx_out    = 8'h00;
    rx_vld    = 1'b0;
    repeat (3) tick();
    check("reset outs", outs(), 32'd0);
    check("reset counters", {frame_cnt, timeout_cnt}, 32'd0);
    rst = 1'b1;
    tick();
    check("post-reset idle", outs(), 32'd0);

    // Stall, grant of port 1, ready ignored at cnt 0, req drop, data and tag path
    for (int i = 0; i < 8; i++) begin
      port_req  = tbl[i].req;
      port_data = {8'hE3, 8'hE2, tbl[i].pd1, 8'hE0};
      rx_ready  = tbl[i].rdy;
      rx_vld    = tbl[i].vld;
      rx_out    = tbl[i].rout;
      tick();
      check($sformatf("vec%0d", i), outs(),
            {1'b0, tbl[i].e_gnt, tbl[i].e_start, tbl[i].e_rrst, tbl[i].e_done, tbl[i].e_dport,
             tbl[i].e_dto, tbl[i].e_ovld, tbl[i].e_odata, tbl[i].e_oport, tbl[i].e_rxd});
    end
    rx_vld = 1'b0;
    rx_out = 8'h00;
    check("frame_cnt after vec", 32'(frame_cnt), 32'd1);

    // Single requester on port 2, 30 BUSY cycles
    port_req = 4'b0100;
    grant_frame("single", 2, 30);
    check("single frame_cnt", 32'(frame_cnt), 32'd2);
    port_req = 4'b0000;

    // Async reset mid-BUSY on port 3
    port_req = 4'b1000;
    rx_ready = 1'b1;
    tick();
    check("pre-reset gnt", 32'(port_gnt), 32'h8);
    rx_ready = 1'b0;
    rx_vld   = 1'b1;
    rx_out   = 8'h77;
    tick();
    tick();
    check("pre-reset out", 32'({out_vld, out_data, out_port}), 32'({1'b1, 8'h77, 3'd3}));
    #2 rst = 1'b0;
    #1;
    check("async reset outs", outs(), 32'd0);
    check("async reset counters", {frame_cnt, timeout_cnt}, 32'd0);
    rx_vld = 1'b0;
    rx_out = 8'h00;
    @(negedge clk);
    rst = 1'b1;

    // Round robin with all requests held, 10-cycle frames
    port_req = 4'b1111;
    grant_frame("rr0", 0, 10);
    grant_frame("rr1", 1, 10);
    grant_frame("rr2", 2, 10);
    grant_frame("rr3", 3, 10);
    grant_frame("rr0b", 0, 10);
    check("rr frame_cnt", 32'(frame_cnt), 32'd5);

    // Timeout on port 1 with rx_ready stuck low
    rx_ready = 1'b1;
    tick();
    check("to gnt", 32'({port_gnt, rx_start}), 32'({4'b0010, 1'b1}));
    rx_ready = 1'b0;
    eg = 4'b0010;
    held = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      tick();
      if (port_gnt == eg && !rx_rst && !done) held++;
    end
    check("to hold", held, 32'd32);
    tick();
    check("to abort", 32'({rx_rst, done, done_timeout, port_gnt}), 32'({1'b1, 1'b1, 1'b1, 4'b0000}));
    check("to done_port", 32'(done_port), 32'd1);
    check("to timeout_cnt", 32'(timeout_cnt), 32'd1);
    rx_ready = 1'b1;
    tick();
    check("to after abort", 32'({rx_rst, done, port_gnt}), 32'd0);

    // Next grant to port 2; ready arrives exactly at cnt == MAX-1
    grant_frame("simul", 2, 32);
    check("simul counters", {frame_cnt, timeout_cnt}, {16'd6, 16'd1});
    tick();
    check("simul no abort", 32'({rx_rst, done, done_timeout}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/recv_sched.md
# recv_sched

Round-robin scheduler that shares one Ethernet frame receiver (byte-stream `start`/`ready`/`data` in, `out`/`vld` out) among `NUM_PORTS` byte-stream sources. It grants one port per frame and pulses the receiver's start. It muxes the granted port's bytes onto the receiver and tags the receiver's output with the port index. It detects frame completion or timeout and recovers a hung receiver with a one-cycle synchronous reset.

## Interface
- `NUM_PORTS`, 4: number of requesting sources (2..8).
- `MAX_FRAME_CYCLES`, 16'd1600: BUSY-cycle limit before abort.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `port_req` input NUM_PORTS: port has a frame ready; held until granted frame ends.
- `port_data` input 8*NUM_PORTS: byte of port i at `[i*8+:8]`.
- `port_gnt` output NUM_PORTS: one-hot grant; the granted port presents one new byte per cycle while its bit is high.
- `rx_data` output 8: byte to the receiver.
- `rx_start` output 1: one-cycle start pulse to the receiver.
- `rx_rst` output 1: one-cycle active-high synchronous reset to the receiver (abort).
- `rx_ready` input 1: receiver idle.
- `rx_out` input 8, `rx_vld` input 1: receiver result stream.
- `out_data` output 8, `out_vld` output 1, `out_port` output 3: registered, tagged result stream.
- `done` output 1, `done_port` output 3, `done_timeout` output 1: per-frame completion pulse.
- `frame_cnt` output 16, `timeout_cnt` output 16: completed and aborted frame counters, saturating.

## Operation
- States: IDLE, START, BUSY, ABORT.
- IDLE: if `|port_req` and `rx_ready`, select the winner round-robin and go to START. Search starts at `(last+1) mod NUM_PORTS`, where `last` is the previous winner. `last` resets to NUM_PORTS-1, so port 0 wins first.
- START: `rx_start`=1 and `port_gnt[win]`=1. Go to BUSY with the cycle counter `cnt` cleared.
- BUSY:
  - `port_gnt[win]`=1 and `cnt` increments every cycle.
  - `rx_ready` is ignored while `cnt`==0, because the receiver drops ready one cycle after start.
  - With `cnt`≥1 and `rx_ready`=1: pulse `done` (`done_timeout`=0), increment `frame_cnt`, set `last`=`win`, go to IDLE.
  - Else, when `cnt`==MAX_FRAME_CYCLES-1: go to ABORT.
- ABORT (1 cycle): `rx_rst`=1, `port_gnt`=0, pulse `done` with `done_timeout`=1, increment `timeout_cnt`, set `last`=`win`, go to IDLE.
- `rx_data` = `port_data[win]` while `port_gnt` is non-zero, else 8'h00.
- Result tagging: `out_vld`/`out_data` register `rx_vld`/`rx_out` every cycle. `out_port` registers `win` whenever `rx_vld`=1. Receiver results after `done` (its SUCCESS/ERROR cycle) still carry the tag of the just-finished frame.
- A port dropping `port_req` mid-grant does not end the frame; only `rx_ready` or a timeout ends it.
- Counters saturate at 16'hFFFF.

## Timing
- All outputs register from state; no combinational path from `port_req` to `port_gnt`.
- Reset values: state IDLE; `port_gnt`, `rx_start`, `rx_rst`, `done`, `done_timeout`, `out_vld` = 0; `rx_data`, `out_data` = 8'h00; `out_port`, `done_port` = 0; both counters 0; `last` = NUM_PORTS-1.
- Latency:
  - `port_req` rising in IDLE → `rx_start` and `port_gnt` high 1 cycle later, in START.
  - `rx_vld` → `out_vld` 1 cycle.
  - `rx_ready` high in BUSY → `done` the next cycle, IDLE the same cycle.
- Minimum gap between consecutive grants is 1 IDLE cycle.
- `rx_ready`=0 in IDLE stalls arbitration indefinitely, with no grant.
- Reset asserted mid-frame returns to IDLE immediately (asynchronous) and drives `rx_rst`=0. The receiver is expected to be reset by the same system reset.
- A timeout and `rx_ready` in the same cycle: completion wins, with no abort.

## Test plan
- Single requester: `port_req`=4'b0100, receiver completes after 30 BUSY cycles → `port_gnt`=4'b0100 for START+30 cycles, then `done`=1, `done_port`=2, `done_timeout`=0, `frame_cnt`=1.
- Round robin: all four requests held continuously, each frame 10 cycles → grant order 0,1,2,3,0; exactly 1 IDLE cycle between grants.
- Timeout: `MAX_FRAME_CYCLES`=20, `rx_ready` stuck 0 → `rx_rst`=1 for exactly 1 cycle after 20 BUSY cycles, `done_timeout`=1, `timeout_cnt`=1, next grant goes to the following port.
- Data/tag path: port 1 bytes 8'h55,8'hD5,… routed to `rx_data`; `rx_vld`=1 with `rx_out`=8'hA3 → `out_vld`=1, `out_data`=8'hA3, `out_port`=1 one cycle later.
- Stall and async reset: `port_req` high while `rx_ready`=0 → no grant. Then deassert `rst` mid-BUSY → all outputs at reset values immediately, and after release port 0 wins first.
- Simultaneous: `rx_ready` rises in the same cycle `cnt` hits MAX_FRAME_CYCLES-1 → normal `done`, `done_timeout`=0, no `rx_rst`.
